// File: rtl/psram_spi_responder.sv
// SPI-mode PSRAM device responder backed by an internal byte RAM.
// ce/sclk/mosi are oversampled on clk, so the whole design runs in one clock domain.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ce high or transaction not started; waiting for ce fall
// CMD    | shifting in 8-bit opcode
// ADDR   | shifting in 24-bit address (low ADDR_W bits kept)
// DUMMY  | fast read: 8 ignored clocks before data
// RDATA  | driving read/ID bytes on miso, shifted on sclk falls
// WDATA  | assembling write bytes, committing each on its 8th rise
// IGNORE | unsupported or no-op opcode; wait for ce rise
module psram_spi_responder #(
  parameter int          ADDR_W      = 12,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  KGD_ID      = 8'h5D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psram_ce,
  input  logic              psram_sclk,
  input  logic              psram_mosi,
  output logic              psram_miso,
  output logic              miso_oe,
  output logic              busy,
  output logic              err_cmd,
  input  logic [ADDR_W-1:0] bd_a,
  output logic [7:0]        bd_q
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_DUMMY  = 3'd3;
  localparam logic [2:0] S_RDATA  = 3'd4;
  localparam logic [2:0] S_WDATA  = 3'd5;
  localparam logic [2:0] S_IGNORE = 3'd6;

  localparam logic [1:0] M_RD   = 2'd0;
  localparam logic [1:0] M_FAST = 2'd1;
  localparam logic [1:0] M_WR   = 2'd2;
  localparam logic [1:0] M_ID   = 2'd3;

  logic [SYNC_STAGES-1:0] ce_sync_q, ce_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   ce_prev_q, ce_prev_d;
  logic                   sclk_prev_q, sclk_prev_d;

  logic [2:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [4:0]        bitcnt_q, bitcnt_d;
  logic [6:0]        shreg_q, shreg_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [6:0]        oshr_q, oshr_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic              err_q, err_d;
  logic [1:0]        idx_q, idx_d;

  logic              ce_s, sclk_s, mosi_s;
  logic              ce_rise, ce_fall, sclk_rise, sclk_fall;
  logic [7:0]        mosi_byte;
  logic [7:0]        byte_src;

  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic [7:0]        ram_rdata_q;
  logic [7:0]        bd_q_q;
  logic [7:0]        mem [2**ADDR_W];

  assign ce_s   = ce_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign ce_rise   = ~ce_prev_q & ce_s;
  assign ce_fall   = ce_prev_q & ~ce_s;
  assign sclk_rise = sclk_s & ~sclk_prev_q & ~ce_s;
  assign sclk_fall = ~sclk_s & sclk_prev_q & ~ce_s;

  assign mosi_byte = {shreg_q, mosi_s};

  always_comb begin
    byte_src = ram_rdata_q;
    if (mode_q == M_ID) begin
      case (idx_q)
        2'd0:    byte_src = 8'h0D;
        2'd1:    byte_src = KGD_ID;
        default: byte_src = 8'h00;
      endcase
    end
  end

  always_comb begin
    ce_sync_d   = {ce_sync_q[SYNC_STAGES-2:0], psram_ce};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], psram_sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], psram_mosi};
    ce_prev_d   = ce_s;
    sclk_prev_d = sclk_s;

    state_d   = state_q;
    mode_d    = mode_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    addr_d    = addr_q;
    oshr_d    = oshr_q;
    miso_d    = miso_q;
    oe_d      = oe_q;
    err_d     = err_q;
    idx_d     = idx_q;
    ram_we    = 1'b0;
    ram_wdata = mosi_byte;
    ram_re    = 1'b0;
    ram_raddr = addr_q;

    if (ce_rise) begin
      // Any partially shifted byte is simply dropped with the counter.
      state_d  = S_IDLE;
      oe_d     = 1'b0;
      miso_d   = 1'b0;
      bitcnt_d = 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ce_fall) begin
            state_d  = S_CMD;
            bitcnt_d = 5'd0;
          end
        end
        S_CMD: begin
          if (sclk_rise) begin
            shreg_d = mosi_byte[6:0];
            if (bitcnt_q == 5'd7) begin
              bitcnt_d = 5'd0;
              case (mosi_byte)
                8'h03: begin mode_d = M_RD;   state_d = S_ADDR; end
                8'h0B: begin mode_d = M_FAST; state_d = S_ADDR; end
                8'h02: begin mode_d = M_WR;   state_d = S_ADDR; end
                8'h9F: begin mode_d = M_ID;   state_d = S_ADDR; end
                8'h66, 8'h99: state_d = S_IGNORE;
                default: begin
                  state_d = S_IGNORE;
                  err_d   = 1'b1;
                end
              endcase
            end else begin
              bitcnt_d = bitcnt_q + 5'd1;
            end
          end
        end
        S_ADDR: begin
          if (sclk_rise) begin
            addr_d = {addr_q[ADDR_W-2:0], mosi_s};
            if (bitcnt_q == 5'd23) begin
              bitcnt_d = 5'd0;
              idx_d    = 2'd0;
              case (mode_q)
                M_FAST:  state_d = S_DUMMY;
                M_WR:    state_d = S_WDATA;
                default: begin
                  state_d   = S_RDATA;
                  ram_re    = 1'b1;
                  ram_raddr = addr_d;
                end
              endcase
            end else begin
              bitcnt_d = bitcnt_q + 5'd1;
            end
          end
        end
        S_DUMMY: begin
          if (sclk_rise) begin
            if (bitcnt_q == 5'd7) begin
              bitcnt_d = 5'd0;
              ram_re   = 1'b1;
              state_d  = S_RDATA;
            end else begin
              bitcnt_d = bitcnt_q + 5'd1;
            end
          end
        end
        S_RDATA: begin
          if (sclk_fall) begin
            oe_d = 1'b1;
            // bitcnt 0 on a fall means a fresh byte is due.
            if (bitcnt_q[2:0] == 3'd0) begin
              miso_d = byte_src[7];
              oshr_d = byte_src[6:0];
            end else begin
              miso_d = oshr_q[6];
              oshr_d = {oshr_q[5:0], 1'b0};
            end
          end else if (sclk_rise) begin
            if (bitcnt_q == 5'd7) begin
              bitcnt_d  = 5'd0;
              addr_d    = addr_q + ADDR_W'(1);
              ram_re    = 1'b1;
              ram_raddr = addr_d;
              if (idx_q != 2'd2) idx_d = idx_q + 2'd1;
            end else begin
              bitcnt_d = bitcnt_q + 5'd1;
            end
          end
        end
        S_WDATA: begin
          if (sclk_rise) begin
            shreg_d = mosi_byte[6:0];
            if (bitcnt_q == 5'd7) begin
              bitcnt_d = 5'd0;
              ram_we   = 1'b1;
              addr_d   = addr_q + ADDR_W'(1);
            end else begin
              bitcnt_d = bitcnt_q + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ce_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ce_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
      state_q     <= S_IDLE;
      mode_q      <= M_RD;
      bitcnt_q    <= 5'd0;
      shreg_q     <= 7'd0;
      addr_q      <= '0;
      oshr_q      <= 7'd0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= 2'd0;
    end else begin
      ce_sync_q   <= ce_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ce_prev_q   <= ce_prev_d;
      sclk_prev_q <= sclk_prev_d;
      state_q     <= state_d;
      mode_q      <= mode_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      addr_q      <= addr_d;
      oshr_q      <= oshr_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
    end
  end

  // RAM is not reset; the backdoor port sees pre-write data on a same-cycle collision.
  always_ff @(posedge clk) begin
    if (ram_we) mem[addr_q] <= ram_wdata;
    if (ram_re) ram_rdata_q <= mem[ram_raddr];
    bd_q_q <= mem[bd_a];
  end

  assign psram_miso = miso_q;
  assign miso_oe    = oe_q;
  assign busy       = (state_q != S_IDLE);
  assign err_cmd    = err_q;
  assign bd_q       = bd_q_q;

endmodule

// File: tb/tb_psram_spi_responder.sv
// Self-checking bench for psram_spi_responder: drives SPI mode-0 transactions and
// compares against a byte-array model of the PSRAM contents.
module tb_psram_spi_responder;
  localparam int AW   = 12;
  localparam int HALF = 60;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          psram_ce = 1'b1;
  logic          psram_sclk = 1'b0;
  logic          psram_mosi = 1'b0;
  logic          psram_miso, miso_oe, busy, err_cmd;
  logic [AW-1:0] bd_a = '0;
  logic [7:0]    bd_q;

  int checks = 0;
  int failures = 0;

  logic [7:0] model [4096];
  logic [7:0] wbuf [16];
  logic [7:0] rbuf [16];

  psram_spi_responder #(.ADDR_W(AW), .SYNC_STAGES(2), .KGD_ID(8'h5D)) dut (
    .clk(clk), .rst_n(rst_n), .psram_ce(psram_ce), .psram_sclk(psram_sclk),
    .psram_mosi(psram_mosi), .psram_miso(psram_miso), .miso_oe(miso_oe),
    .busy(busy), .err_cmd(err_cmd), .bd_a(bd_a), .bd_q(bd_q)
  );

  always #5 clk = ~clk;

  task automatic realign;
    @(negedge clk);
    #2;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx, output logic [7:0] oe);
    rx = 8'h00;
    oe = 8'h00;
    for (int i = 7; i >= 8 - n; i--) begin
      psram_mosi = tx[i];
      #HALF;
      rx[i] = psram_miso;
      oe[i] = miso_oe;
      psram_sclk = 1'b1;
      #HALF;
      psram_sclk = 1'b0;
    end
  endtask

  task automatic cs_begin;
    psram_ce = 1'b0;
    #HALF;
  endtask

  task automatic cs_end;
    #HALF;
    psram_ce = 1'b1;
    #(4*HALF);
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [23:0] a, output logic oe_seen);
    logic [7:0] rx, oe;
    oe_seen = 1'b0;
    spi_bits(op, 8, rx, oe);         oe_seen |= |oe;
    spi_bits(a[23:16], 8, rx, oe);   oe_seen |= |oe;
    spi_bits(a[15:8], 8, rx, oe);    oe_seen |= |oe;
    spi_bits(a[7:0], 8, rx, oe);     oe_seen |= |oe;
  endtask

  // Writes n bytes from wbuf, then `extra` bits of an uncommitted byte.
  task automatic spi_write(input logic [23:0] a, input int n, input int extra);
    logic [7:0] rx, oe;
    logic seen;
    logic [11:0] ad;
    cs_begin;
    send_hdr(8'h02, a, seen);
    for (int i = 0; i < n; i++) begin
      spi_bits(wbuf[i], 8, rx, oe);
      ad = a[11:0] + 12'(i);
      model[ad] = wbuf[i];
    end
    if (extra > 0) spi_bits(8'($urandom), extra, rx, oe);
    cs_end;
  endtask

  task automatic spi_read(input logic [7:0] op, input logic [23:0] a, input int n,
                          output logic hdr_oe, output logic data_oe_ok);
    logic [7:0] rx, oe;
    cs_begin;
    send_hdr(op, a, hdr_oe);
    if (op == 8'h0B) begin
      spi_bits(8'($urandom), 8, rx, oe);
      hdr_oe |= |oe;
    end
    data_oe_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      spi_bits(8'($urandom), 8, rx, oe);
      rbuf[i] = rx;
      if (oe !== 8'hFF) data_oe_ok = 1'b0;
    end
    cs_end;
  endtask

  function automatic logic [7:0] exp_byte(input logic [7:0] op, input logic [23:0] a, input int i);
    logic [11:0] ad;
    if (op == 8'h9F) return (i == 0) ? 8'h0D : (i == 1) ? 8'h5D : 8'h00;
    ad = a[11:0] + 12'(i);
    return model[ad];
  endfunction

  task automatic bd_read(input logic [AW-1:0] a, output logic [7:0] q);
    @(negedge clk);
    bd_a = a;
    @(negedge clk);
    #1;
    q = bd_q;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({psram_miso, miso_oe, busy, err_cmd} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs: miso/oe/busy/err got %b expected 0000", {psram_miso, miso_oe, busy, err_cmd});
    end
    rst_n = 1'b1;
    realign;
  endtask

  task automatic test_write;
    logic [7:0] q;
    logic [7:0] rx, oe;
    logic seen;
    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A; wbuf[2] = 8'h3C;
    cs_begin;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL write_busy_high: busy got %b expected 1", busy);
    end
    send_hdr(8'h02, 24'h000010, seen);
    for (int i = 0; i < 3; i++) begin
      spi_bits(wbuf[i], 8, rx, oe);
      model[12'h010 + 12'(i)] = wbuf[i];
    end
    cs_end;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL write_busy_low: busy got %b expected 0", busy);
    end
    for (int i = 0; i < 3; i++) begin
      bd_read(12'h010 + 12'(i), q);
      checks++;
      if (q !== model[12'h010 + 12'(i)]) begin
        failures++;
        $display("FAIL write_bd[%0d]: bd_q got %h expected %h", i, q, model[12'h010 + 12'(i)]);
      end
    end
  endtask

  task automatic test_read;
    logic hdr_oe, data_ok;
    spi_read(8'h03, 24'h000010, 3, hdr_oe, data_ok);
    checks++;
    if (hdr_oe !== 1'b0 || data_ok !== 1'b1) begin
      failures++;
      $display("FAIL read_oe: hdr_oe got %b expected 0, data_oe_ok got %b expected 1", hdr_oe, data_ok);
    end
    checks++;
    if (miso_oe !== 1'b0) begin
      failures++;
      $display("FAIL read_oe_after_ce: miso_oe got %b expected 0", miso_oe);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rbuf[i] !== exp_byte(8'h03, 24'h000010, i)) begin
        failures++;
        $display("FAIL read_byte[%0d]: miso got %h expected %h", i, rbuf[i], exp_byte(8'h03, 24'h000010, i));
      end
    end
  endtask

  task automatic test_fast_wrap;
    logic hdr_oe, data_ok;
    logic [23:0] a;
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    spi_write(24'h000FFF, 2, 0);
    a = {12'($urandom), 12'hFFF};
    spi_read(8'h0B, a, 2, hdr_oe, data_ok);
    checks++;
    if (hdr_oe !== 1'b0 || data_ok !== 1'b1) begin
      failures++;
      $display("FAIL fast_oe: hdr_oe got %b expected 0, data_oe_ok got %b expected 1", hdr_oe, data_ok);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rbuf[i] !== exp_byte(8'h0B, a, i)) begin
        failures++;
        $display("FAIL fast_byte[%0d]: miso got %h expected %h", i, rbuf[i], exp_byte(8'h0B, a, i));
      end
    end
  endtask

  task automatic test_id_and_err;
    logic hdr_oe, data_ok, seen;
    logic [7:0] rx, oe;
    logic [23:0] a;
    a = 24'($urandom);
    spi_read(8'h9F, a, 4, hdr_oe, data_ok);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rbuf[i] !== exp_byte(8'h9F, a, i)) begin
        failures++;
        $display("FAIL id_byte[%0d]: miso got %h expected %h", i, rbuf[i], exp_byte(8'h9F, a, i));
      end
    end
    cs_begin;
    spi_bits(8'h66, 8, rx, oe);
    cs_end;
    checks++;
    if (err_cmd !== 1'b0) begin
      failures++;
      $display("FAIL err_after_valid: err_cmd got %b expected 0", err_cmd);
    end
    cs_begin;
    send_hdr(8'h5A, 24'($urandom), seen);
    spi_bits(8'($urandom), 8, rx, oe);
    seen |= |oe;
    cs_end;
    checks++;
    if (err_cmd !== 1'b1 || seen !== 1'b0) begin
      failures++;
      $display("FAIL err_bad_opcode: err_cmd got %b expected 1, oe_seen got %b expected 0", err_cmd, seen);
    end
  endtask

  task automatic test_partial_write;
    logic [7:0] q;
    logic hdr_oe, data_ok;
    wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
    spi_write(24'h000020, 2, 0);
    wbuf[0] = 8'($urandom);
    spi_write(24'h000020, 0, 1 + int'($urandom_range(6)));
    bd_read(12'h020, q);
    checks++;
    if (q !== model[12'h020]) begin
      failures++;
      $display("FAIL partial_unchanged: bd_q got %h expected %h", q, model[12'h020]);
    end
    wbuf[0] = 8'($urandom);
    spi_write(24'h000020, 1, 4);
    bd_read(12'h021, q);
    checks++;
    if (q !== model[12'h021]) begin
      failures++;
      $display("FAIL partial_12bit_next: bd_q got %h expected %h", q, model[12'h021]);
    end
    spi_read(8'h03, 24'h000020, 2, hdr_oe, data_ok);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rbuf[i] !== exp_byte(8'h03, 24'h000020, i)) begin
        failures++;
        $display("FAIL partial_read[%0d]: miso got %h expected %h", i, rbuf[i], exp_byte(8'h03, 24'h000020, i));
      end
    end
  endtask

  task automatic test_reset_mid_read;
    logic [7:0] rx, oe;
    logic seen, hdr_oe, data_ok;
    for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
    spi_write(24'h000100, 4, 0);
    cs_begin;
    send_hdr(8'h03, 24'h000100, seen);
    spi_bits(8'h00, 8, rx, oe);
    spi_bits(8'h00, 3, rx, oe);
    checks++;
    if (busy !== 1'b1 || miso_oe !== 1'b1) begin
      failures++;
      $display("FAIL midread_active: busy got %b oe got %b expected 1 1", busy, miso_oe);
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (miso_oe !== 1'b0 || busy !== 1'b0 || err_cmd !== 1'b0) begin
      failures++;
      $display("FAIL midread_reset: oe/busy/err got %b%b%b expected 000", miso_oe, busy, err_cmd);
    end
    rst_n = 1'b1;
    #2;
    psram_ce = 1'b1;
    #(4*HALF);
    spi_read(8'h03, 24'h000101, 3, hdr_oe, data_ok);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rbuf[i] !== exp_byte(8'h03, 24'h000101, i)) begin
        failures++;
        $display("FAIL postreset_read[%0d]: miso got %h expected %h", i, rbuf[i], exp_byte(8'h03, 24'h000101, i));
      end
    end
  endtask

  task automatic test_back_to_back;
    logic hdr_oe, data_ok;
    logic [23:0] a;
    logic [7:0] op, q;
    int n;
    for (int t = 0; t < 6; t++) begin
      a = 24'($urandom);
      n = 1 + int'($urandom_range(5));
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      spi_write(a, n, 0);
      op = ($urandom_range(1) == 0) ? 8'h03 : 8'h0B;
      spi_read(op, a, n, hdr_oe, data_ok);
      checks++;
      if (hdr_oe !== 1'b0 || data_ok !== 1'b1) begin
        failures++;
        $display("FAIL b2b_oe[%0d]: hdr_oe got %b expected 0, data_oe_ok got %b expected 1", t, hdr_oe, data_ok);
      end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (rbuf[i] !== exp_byte(op, a, i)) begin
          failures++;
          $display("FAIL b2b_byte[%0d][%0d]: op %h miso got %h expected %h", t, i, op, rbuf[i], exp_byte(op, a, i));
        end
      end
      bd_read(a[11:0] + 12'(n - 1), q);
      checks++;
      if (q !== exp_byte(8'h03, a, n - 1)) begin
        failures++;
        $display("FAIL b2b_bd[%0d]: bd_q got %h expected %h", t, q, exp_byte(8'h03, a, n - 1));
      end
      realign;
    end
  endtask

  initial begin
    #2;
    test_reset;
    test_write;
    test_read;
    test_fast_wrap;
    test_id_and_err;
    test_partial_write;
    test_reset_mid_read;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
